// File: rtl/processor_pio_in.sv
// Avalon-MM parallel input port: synchronizes and optionally debounces in_port, latches
// per-bit edges into a write-1-to-clear capture register and raises a maskable level irq.
module processor_pio_in #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (DEBOUNCE_CYCLES > 0) ? CntW'(DEBOUNCE_CYCLES - 1) : '0;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;
    logic [WIDTH-1:0] r_ecap;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;
    logic [CntW-1:0]  r_cnt [WIDTH];

    logic [WIDTH-1:0] w_filt_nxt;
    logic [CntW-1:0]  w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_clr          = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    // Per-bit debounce: the filtered level follows s2 only after it has differed long enough.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_filt_nxt[i] = r_filt[i];
            w_cnt_nxt[i]  = '0;
            if (DEBOUNCE_CYCLES == 0) begin
                w_filt_nxt[i] = r_s2[i];
            end else if (r_s2[i] != r_filt[i]) begin
                if (r_cnt[i] == CntLast) begin
                    w_filt_nxt[i] = r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        w_edge = r_filt ^ r_filt_d;
        if (EDGE_TYPE == 0) begin
            w_edge = r_filt & ~r_filt_d;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~r_filt & r_filt_d;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = r_filt;
            2'd2:    w_rdata[WIDTH-1:0] = r_mask;
            2'd3:    w_rdata[WIDTH-1:0] = r_ecap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_filt     <= '0;
            r_filt_d   <= '0;
            r_ecap     <= '0;
            r_mask     <= '0;
            r_readdata <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_filt     <= w_filt_nxt;
            r_filt_d   <= r_filt;
            // A new edge beats a simultaneous clear of the same bit.
            r_ecap     <= (r_ecap & ~w_clr) | w_edge;
            r_readdata <= w_rdata;
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_ecap & r_mask);

endmodule

// File: tb/tb_processor_pio_in.sv
// Scoreboard bench for processor_pio_in: four instances cover no-debounce, debounce,
// falling-edge and any-edge configurations on a shared bus with per-instance chipselect.
module tb_processor_pio_in;

    typedef struct {
        int          dut;
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic [3:0]  cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  ip [4];
    logic [31:0] rdata [4];
    logic [3:0]  irq_v;
    logic        rd_req;
    logic        rd_flag_q;
    int          n_cmp;
    int          n_err;
    exp_t        sb [$];

    processor_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[0]), .in_port(ip[0]), .irq(irq_v[0])
    );
    processor_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[1]), .in_port(ip[1]), .irq(irq_v[1])
    );
    processor_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[2]), .in_port(ip[2]), .irq(irq_v[2])
    );
    processor_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_dut3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[3]), .in_port(ip[3]), .irq(irq_v[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rd_flag_q <= rd_req;

    // Each entry checks readdata and irq as seen just after the edge following the request.
    initial begin
        exp_t e;
        n_cmp = 0;
        n_err = 0;
        forever begin
            @(negedge clk);
            if (rd_flag_q) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL scoreboard_empty: read presented with no expectation queued");
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (rdata[e.dut] !== e.rd) begin
                        n_err++;
                        $display("FAIL %s dut%0d readdata: got %h want %h",
                                 e.name, e.dut, rdata[e.dut], e.rd);
                    end
                    n_cmp++;
                    if (irq_v[e.dut] !== e.irq) begin
                        n_err++;
                        $display("FAIL %s dut%0d irq: got %b want %b",
                                 e.name, e.dut, irq_v[e.dut], e.irq);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input int d, input logic [1:0] a, input logic [31:0] er,
                          input logic ei, input string nm);
        exp_t e;
        e.dut  = d;
        e.rd   = er;
        e.irq  = ei;
        e.name = nm;
        sb.push_back(e);
        address = a;
        rd_req  = 1'b1;
        @(negedge clk);
        rd_req  = 1'b0;
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] w);
        cs        = 4'b0001 << d;
        write_n   = 1'b0;
        address   = a;
        writedata = w;
        @(negedge clk);
        cs        = '0;
        write_n   = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        cs        = '0;
        write_n   = 1'b1;
        address   = '0;
        writedata = '0;
        rd_req    = 1'b0;
        ip[0]     = 4'h0;
        ip[1]     = 4'h0;
        ip[2]     = 4'hF;
        ip[3]     = 4'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        sample(0, 2'd0, 32'h0, 1'b0, "rst_data");
        sample(0, 2'd2, 32'h0, 1'b0, "rst_mask");
        sample(0, 2'd3, 32'h0, 1'b0, "rst_ecap");
        for (int d = 1; d < 4; d++) sample(d, 2'd3, 32'h0, 1'b0, "rst_ecap_all");

        // Basic capture and write-1-to-clear
        wr(0, 2'd2, 32'hF);
        ip[0] = 4'h5;
        tick();
        tick();
        sample(0, 2'd0, 32'h0, 1'b0, "filt_pre");
        sample(0, 2'd0, 32'h5, 1'b1, "filt_k3");
        sample(0, 2'd3, 32'h5, 1'b1, "ecap_5");
        wr(0, 2'd3, 32'h1);
        sample(0, 2'd3, 32'h4, 1'b1, "ecap_clr0");
        wr(0, 2'd3, 32'h4);
        sample(0, 2'd3, 32'h0, 1'b0, "ecap_clr2");

        // Falling edge ignored, then clear colliding with a new rising edge
        ip[0] = 4'h4;
        repeat (5) tick();
        sample(0, 2'd3, 32'h0, 1'b0, "fall_ignored");
        ip[0] = 4'h5;
        repeat (3) tick();
        wr(0, 2'd3, 32'h1);
        sample(0, 2'd3, 32'h1, 1'b1, "collide");
        wr(0, 2'd3, 32'hF);
        sample(0, 2'd3, 32'h0, 1'b0, "clr_all");

        // Debounce: 2-cycle glitch rejected, long level accepted
        wr(1, 2'd2, 32'hF);
        ip[1] = 4'h2;
        tick();
        tick();
        ip[1] = 4'h0;
        repeat (8) tick();
        sample(1, 2'd0, 32'h0, 1'b0, "glitch_filt");
        sample(1, 2'd3, 32'h0, 1'b0, "glitch_ecap");
        ip[1] = 4'h2;
        tick();
        tick();
        sample(1, 2'd3, 32'h0, 1'b0, "db_early");
        repeat (4) tick();
        sample(1, 2'd3, 32'h2, 1'b1, "db_ecap");
        sample(1, 2'd0, 32'h2, 1'b1, "db_filt");

        // Falling-edge instance with mask 0, then unmask
        sample(2, 2'd3, 32'h0, 1'b0, "fall_only_rise");
        ip[2] = 4'h0;
        repeat (5) tick();
        sample(2, 2'd3, 32'hF, 1'b0, "fall_cap");
        wr(2, 2'd2, 32'h2);
        sample(2, 2'd2, 32'h2, 1'b1, "mask_irq");

        // Any-edge instance captures both transitions
        ip[3] = 4'h8;
        repeat (5) tick();
        sample(3, 2'd3, 32'h8, 1'b0, "any_rise");
        wr(3, 2'd3, 32'h8);
        sample(3, 2'd3, 32'h0, 1'b0, "any_clr");
        ip[3] = 4'h0;
        repeat (5) tick();
        sample(3, 2'd3, 32'h8, 1'b0, "any_fall");

        // Reset mid-operation with ecap=A and a debounce count running
        ip[0] = 4'h1;
        ip[1] = 4'hA;
        repeat (8) tick();
        sample(1, 2'd3, 32'hA, 1'b1, "ecap_A");
        ip[1] = 4'hE;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sample(1, 2'd3, 32'h0, 1'b0, "mid_rst_ecap");
        sample(1, 2'd2, 32'h0, 1'b0, "mid_rst_mask");
        sample(1, 2'd0, 32'h0, 1'b0, "mid_rst_filt");
        sample(0, 2'd3, 32'h0, 1'b0, "rst_hi_pre");
        sample(0, 2'd3, 32'h1, 1'b0, "rst_hi_ecap");
        sample(0, 2'd0, 32'h1, 1'b0, "rst_hi_filt");
        repeat (6) tick();
        sample(1, 2'd3, 32'hE, 1'b0, "rst_db_ecap");

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
